// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: handshake bundle between an operand source / product sink
// and wallace_mult_pipe. The in_signed line exists only when WALLACE_MULT_SIGNED_EN
// is defined.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
`ifdef WALLACE_MULT_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               busy;

`ifdef WALLACE_MULT_SIGNED_EN
  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_prod, busy
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );
`endif
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage pipelined Wallace-tree multiplier with a single
// global stall (advance = !out_valid | out_ready).
//   S1 (_p0): operand registers
//   S2 (_p1): carry-save sum/carry pair out of the half/full-adder tree
//   S3 (_p2): carry-propagate product
// Optional build macro WALLACE_MULT_SIGNED_EN adds in_signed and Baugh-Wooley
// partial products for two's-complement operands.
module wallace_mult_pipe #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  wallace_mult_pipe_if.slave bus
);
  localparam int PW     = 2 * WIDTH;
  localparam int MAXH   = WIDTH + 2;  // tallest column ever seen in the tree
  localparam int ROUNDS = 8;          // enough reduction rounds for WIDTH<=16

  logic             advance;
  logic             vld_p0_q, vld_p1_q, vld_p2_q;
  logic [WIDTH-1:0] a_p0_q, b_p0_q;
`ifdef WALLACE_MULT_SIGNED_EN
  logic             sgn_p0_q;
`endif
  logic [PW-1:0]    sum_p1_q, carry_p1_q;
  logic [PW-1:0]    prod_p2_q;
  logic [PW-1:0]    sum_d, carry_d, prod_d;

  // Column-wise bit heap used by the reduction tree.
  logic [MAXH-1:0]  col [PW];
  logic [MAXH-1:0]  nxt [PW];
  int               h   [PW];
  int               nh  [PW];
  logic [MAXH-1:0]  bits;
  logic             pp, x, y, z;
  int               nfa, rem, max_h;

  assign advance      = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_p2_q;
  assign bus.busy     = vld_p0_q | vld_p1_q | vld_p2_q;
  // Invalid slots present zero so a freshly reset block shows out_prod = 0.
  assign bus.out_prod = vld_p2_q ? prod_p2_q : '0;

  // Partial products into columns, then Wallace rounds until every column is <= 2 high.
  always_comb begin
    for (int c = 0; c < PW; c++) begin
      col[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end
    bits    = '0;
    pp      = 1'b0;
    x       = 1'b0;
    y       = 1'b0;
    z       = 1'b0;
    nfa     = 0;
    rem     = 0;
    max_h   = 0;
    sum_d   = '0;
    carry_d = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = a_p0_q[j] & b_p0_q[i];
`ifdef WALLACE_MULT_SIGNED_EN
        // Baugh-Wooley: complement the terms that mix exactly one sign bit.
        if (sgn_p0_q && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
`endif
        col[i+j] = col[i+j] | (MAXH'(pp) << h[i+j]);
        h[i+j]   = h[i+j] + 1;
      end
    end
`ifdef WALLACE_MULT_SIGNED_EN
    // Baugh-Wooley correction constants at weights 2^WIDTH and 2^(2*WIDTH-1).
    if (sgn_p0_q) begin
      col[WIDTH]  = col[WIDTH] | (MAXH'(1'b1) << h[WIDTH]);
      h[WIDTH]    = h[WIDTH] + 1;
      col[PW-1]   = col[PW-1] | (MAXH'(1'b1) << h[PW-1]);
      h[PW-1]     = h[PW-1] + 1;
    end
`endif

    for (int r = 0; r < ROUNDS; r++) begin
      max_h = 0;
      for (int c = 0; c < PW; c++) begin
        if (h[c] > max_h) max_h = h[c];
        nxt[c] = '0;
        nh[c]  = 0;
      end
      for (int c = 0; c < PW; c++) begin
        bits = col[c];
        nfa  = (max_h > 2) ? h[c] / 3 : 0;
        rem  = h[c] - 3 * nfa;
        // Full adders on every complete group of three.
        for (int f = 0; f < MAXH / 3; f++) begin
          if (f < nfa) begin
            x      = bits[0];
            y      = bits[1];
            z      = bits[2];
            bits   = bits >> 3;
            nxt[c] = nxt[c] | (MAXH'(x ^ y ^ z) << nh[c]);
            nh[c]  = nh[c] + 1;
            // Carries out of the top column fall off: the product is mod 2^PW.
            if (c + 1 < PW) begin
              nxt[(c+1)%PW] = nxt[(c+1)%PW] | (MAXH'((x & y) | (x & z) | (y & z)) << nh[(c+1)%PW]);
              nh[(c+1)%PW]  = nh[(c+1)%PW] + 1;
            end
          end
        end
        // A leftover pair gets a half adder; single bits pass straight through.
        if (max_h > 2 && rem == 2) begin
          x      = bits[0];
          y      = bits[1];
          nxt[c] = nxt[c] | (MAXH'(x ^ y) << nh[c]);
          nh[c]  = nh[c] + 1;
          if (c + 1 < PW) begin
            nxt[(c+1)%PW] = nxt[(c+1)%PW] | (MAXH'(x & y) << nh[(c+1)%PW]);
            nh[(c+1)%PW]  = nh[(c+1)%PW] + 1;
          end
        end else begin
          for (int t = 0; t < 2; t++) begin
            if (t < rem) begin
              nxt[c] = nxt[c] | (MAXH'(bits[0]) << nh[c]);
              nh[c]  = nh[c] + 1;
              bits   = bits >> 1;
            end
          end
        end
      end
      for (int c = 0; c < PW; c++) begin
        col[c] = nxt[c];
        h[c]   = nh[c];
      end
    end

    for (int c = 0; c < PW; c++) begin
      sum_d[c]   = col[c][0];
      carry_d[c] = col[c][1];
    end
  end

  assign prod_d = sum_p1_q + carry_p1_q;

  // Valid bits shift together on advance; reset empties the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (advance) begin
      vld_p0_q <= bus.in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Data registers shift on advance and hold during a stall.
  always_ff @(posedge clk) begin
    if (advance) begin
      // S1: operands
      a_p0_q     <= bus.in_a;
      b_p0_q     <= bus.in_b;
`ifdef WALLACE_MULT_SIGNED_EN
      sgn_p0_q   <= bus.in_signed;
`endif
      // S2: carry-save pair
      sum_p1_q   <= sum_d;
      carry_p1_q <= carry_d;
      // S3: final product
      prod_p2_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: randomized and directed bench for wallace_mult_pipe
// (WIDTH=4) against a behavioural a*b pipeline model.
module tb_wallace_mult_pipe;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst;
  logic sgn_drv = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(W)) bus ();
`ifdef WALLACE_MULT_SIGNED_EN
  assign bus.in_signed = sgn_drv;
`endif

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    int sa, sb, p;
    sa = int'(a);
    sb = int'(b);
    if (s && a[W-1]) sa = sa - (1 << W);
    if (s && b[W-1]) sb = sb - (1 << W);
    p = sa * sb;
    return p[PW-1:0];
  endfunction

  // Behavioural model: three latency slots that all move when the output is free or taken.
  logic          m_v [3];
  logic [PW-1:0] m_p [3];
  always @(posedge clk) begin
    if (rst) begin
      m_v[0] <= 1'b0;
      m_v[1] <= 1'b0;
      m_v[2] <= 1'b0;
    end else if (!m_v[2] || bus.out_ready) begin
      m_v[0] <= bus.in_valid;
      m_p[0] <= ref_prod(bus.in_a, bus.in_b, sgn_drv);
      m_v[1] <= m_v[0];
      m_p[1] <= m_p[0];
      m_v[2] <= m_v[1];
      m_p[2] <= m_p[1];
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_v[2]));
      check("in_ready", 32'(bus.in_ready), 32'(!m_v[2] || bus.out_ready));
      check("busy", 32'(bus.busy), 32'(m_v[0] | m_v[1] | m_v[2]));
      if (m_v[2]) check("out_prod", 32'(bus.out_prod), 32'(m_p[2]));
    end
  end

  // Record consumed products.
  int            cons_cnt = 0;
  logic [PW-1:0] cons_q [$];
  logic          arm24 = 1'b0;
  logic          saw24 = 1'b0;
  always @(posedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      cons_cnt <= cons_cnt + 1;
      cons_q.push_back(bus.out_prod);
      if (arm24 && bus.out_prod == PW'(36)) saw24 <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            base;
    int            qn;
    logic [31:0]   r;

    // Reset with a pair presented during reset: it must not be taken.
    rst = 1'b1;
    drive(1'b1, 4'd6, 4'd6);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_prod", 32'(bus.out_prod), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rst_pair_dropped", 32'(bus.out_valid), 32'd0);
    end

    // 15*15: valid three cycles after acceptance, then gone.
    step();
    drive(1'b1, 4'd15, 4'd15);
    step();
    drive(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_c3_prod", 32'(bus.out_prod), 32'hE1);
    @(negedge clk);
    check("lat_c4_valid", 32'(bus.out_valid), 32'd0);

    // Exhaustive back-to-back stream: exactly 256 products in 256+3 cycles.
    step();
    base = cons_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step();
        drive(1'b1, W'(a), W'(b));
      end
    end
    step();
    drive(1'b0, 4'd0, 4'd0);
    repeat (3) step();
    check("exh_count", 32'(cons_cnt - base), 32'd256);
    repeat (2) step();

    // Stall: 3*5 held while out_ready is low, then 7*9 and 2*8 in order.
    base = cons_cnt;
    step(); drive(1'b1, 4'd3, 4'd5);
    step(); drive(1'b1, 4'd7, 4'd9);
    step(); drive(1'b1, 4'd2, 4'd8);
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd1);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_prod", 32'(bus.out_prod), 32'h0F);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    check("stall_r1_prod", 32'(bus.out_prod), 32'h3F);
    @(negedge clk);
    check("stall_r2_prod", 32'(bus.out_prod), 32'h10);
    @(negedge clk);
    check("stall_end_valid", 32'(bus.out_valid), 32'd0);
    check("stall_count", 32'(cons_cnt - base), 32'd3);

    // Reset right after accepting 6*6: it must never emerge.
    step(); drive(1'b1, 4'd6, 4'd6);
    step(); drive(1'b0, 4'd0, 4'd0); rst = 1'b1;
    step(); rst = 1'b0; arm24 = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_0x24", 32'(saw24), 32'd0);
    arm24 = 1'b0;

    // Random traffic with random backpressure and rare resets.
    for (int n = 0; n < 600; n++) begin
      step();
      r             = $urandom;
      rst           = (r[9:0] < 10'd6);
      drive(r[10] | r[11], r[3:0], r[7:4]);
      bus.out_ready = (r[13:12] != 2'b00);
`ifdef WALLACE_MULT_SIGNED_EN
      sgn_drv       = r[14];
`endif
    end
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    bus.out_ready = 1'b1;
    sgn_drv = 1'b0;
    repeat (5) step();

`ifdef WALLACE_MULT_SIGNED_EN
    // Signed products: -8*7, -8*-8, then unsigned 8*8.
    qn = cons_q.size();
    step(); sgn_drv = 1'b1; drive(1'b1, 4'd8, 4'd7);
    step(); sgn_drv = 1'b1; drive(1'b1, 4'd8, 4'd8);
    step(); sgn_drv = 1'b0; drive(1'b1, 4'd8, 4'd8);
    step(); drive(1'b0, 4'd0, 4'd0);
    repeat (5) step();
    check("sgn_count", 32'(cons_q.size() - qn), 32'd3);
    if (cons_q.size() >= qn + 3) begin
      check("sgn_m8x7", 32'(cons_q[qn]), 32'hC8);
      check("sgn_m8xm8", 32'(cons_q[qn+1]), 32'h40);
      check("uns_8x8", 32'(cons_q[qn+2]), 32'h40);
    end
`else
    qn = cons_q.size();
    check("cons_log_size", 32'(qn), 32'(cons_cnt));
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 4, is the operand width in bits; the legal range is 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1 bit: the operand pair is presented.
REQ-005 Port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 Port in_a, input, WIDTH bits: multiplicand.
REQ-007 Port in_b, input, WIDTH bits: multiplier.
REQ-008 Port out_valid, output, 1 bit: out_prod holds a valid product.
REQ-009 Port out_ready, input, 1 bit: the downstream consumes out_prod this cycle.
REQ-010 Port out_prod, output, 2*WIDTH bits: the product.
REQ-011 Port busy, output, 1 bit: at least one pipeline stage holds a valid entry.

Function
REQ-012 The block shall be a 3-stage pipeline:
- S1 registers in_a and in_b;
- S2 registers the carry-save sum/carry pair from Wallace reduction (half/full adder tree) of the WIDTH partial products;
- S3 registers the final carry-propagate sum onto out_prod.
REQ-013 Each stage shall carry a valid bit; out_valid shall equal the S3 valid bit.
REQ-014 A global advance signal shall be defined as advance = !out_valid | out_ready.
- When advance is 1, all stages shift one place.
- When advance is 0, all stage data and valid bits hold unchanged.
REQ-015 in_ready shall equal advance, combinationally.
- A transfer occurs on an edge where in_valid & in_ready are both 1.
- When in_valid=0 and advance=1, a bubble (valid=0) shall enter S1.
REQ-016 With no stall, a pair accepted at edge k shall appear with out_valid=1 after edge k+3, giving a latency of 3 cycles.
REQ-017 Throughput shall be one product per cycle while out_ready=1.
REQ-018 Bubbles shall not be collapsed; ordering shall be strictly FIFO.
REQ-019 While out_valid=1 and out_ready=0, out_prod shall hold stable and in_a/in_b shall be ignored.
REQ-020 On a simultaneous output consume and input accept in the same edge, both transfers shall complete.
REQ-021 In unsigned mode, out_prod shall equal in_a*in_b exactly, with no truncation; the maximum is (2^WIDTH-1)^2.
REQ-022 busy shall be the OR of the three stage valid bits.

Reset
REQ-023 When rst=1 at a rising edge, all valid bits shall clear.
- out_valid=0, busy=0 and out_prod=0 on the following cycle.
- in_ready=1 after reset.
REQ-024 Reset mid-operation shall discard all in-flight entries; none shall appear at the output afterwards.
REQ-025 A pair presented during the reset cycle shall not be accepted.

Configuration
REQ-026 Macro WALLACE_MULT_SIGNED_EN defined:
- the block shall add input port in_signed (1 bit), which is captured in S1 alongside the operands;
- when in_signed=1, the operands are two's complement and out_prod is the 2*WIDTH-bit two's-complement product (Baugh-Wooley partial products);
- when in_signed=0, behaviour is as in REQ-021.
REQ-027 Macro WALLACE_MULT_SIGNED_EN undefined:
- port in_signed shall be absent;
- the block shall be unsigned only;
- the signed partial-product logic shall be absent.

Verification (WIDTH=4)
REQ-028 Reset, then in_a=15, in_b=15 with out_ready=1 -> out_prod=0xE1 and out_valid=1 exactly 3 cycles after acceptance, then out_valid=0.
REQ-029 Exhaustive: all 256 pairs streamed back-to-back with out_ready=1 -> 256 products, in order, one per cycle, each matching the a*b model.
REQ-030 Stream of 3,5 / 7,9 / 2,8 with out_ready=0 on cycles 4-6 -> out_prod=0x0F held and in_ready=0 during the stall, then 0x3F and 0x10 in order, with no loss or duplication.
REQ-031 Accept 6,6 then assert rst on the next edge -> out_valid stays 0, busy=0 after reset, and 0x24 never appears.
REQ-032 Build with WALLACE_MULT_SIGNED_EN:
- in_signed=1, in_a=-8, in_b=7 -> out_prod=0xC8;
- in_a=-8, in_b=-8 -> out_prod=0x40;
- in_signed=0, in_a=8, in_b=8 -> out_prod=0x40.
